// File: rtl/arq_tx_queue.sv
// Stop-and-wait ARQ transmit queue: FIFO of frames, each sent with a
// sequence number and held until ACKed; NACK/timeout retransmits, retry limit drops.
// Ports: clk, rst (async, active-high)
//   write side: wr_en, wr_data, full, empty, count, overflow
//   link side:  tx_valid, tx_ready, tx_data, tx_seq, err_inject
//   ack side:   ack_in, ack_seq, nack_in, done, fail, retry_cnt
module arq_tx_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int SEQ_WIDTH  = 3,
  parameter int TIMEOUT    = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [SEQ_WIDTH-1:0]    tx_seq,
  input  logic                    err_inject,
  input  logic                    ack_in,
  input  logic [SEQ_WIDTH-1:0]    ack_seq,
  input  logic                    nack_in,
  output logic                    done,
  output logic                    fail,
  output logic [((MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY+1))-1:0] retry_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY+1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 overflow_q, overflow_d;
  logic                 push;
  logic                 pop;
  logic                 is_full;

  assign is_full = (count_q == CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    pop        = 1'b0;
    // A write while full is dropped even if a pop frees a slot this cycle.
    push       = wr_en && !is_full;
    overflow_d = wr_en && is_full;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // Valid ACK beats NACK, which beats timeout.
        if (ack_in && (ack_seq == seq_q)) begin
          pop     = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (nack_in ||
                     (timer_q == TW'(TIMEOUT-1))) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = S_SEND;
          end else begin
            pop     = 1'b1;
            fail_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropped frames consume a sequence number just like acked ones.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      seq_d    = seq_q + SEQ_WIDTH'(1);
      retry_d  = '0;
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    count_d    = count_q + CW'(push) - CW'(pop);
    tx_valid_d = (state_d == S_SEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: reads are only meaningful while count > 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign full      = is_full;
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx_valid  = tx_valid_q;
  assign tx_seq    = seq_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  // rd_ptr is frozen until pop, so the head frame is stable across retries.
  assign tx_data   = mem[rd_ptr_q] ^
                     {{(DATA_WIDTH-1){1'b0}}, err_inject};

endmodule
